// File: rtl/div_sched_pkg.sv
// Shared types and default sizing for the divider scheduler.
package div_sched_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 64;

    // Width of a binary index/counter covering 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = clog2_min1(DEF_NREQ);
    localparam int DEF_CNT_W = clog2_min1(DEF_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/div_scheduler_if.sv
// Requester handshakes plus the divider start/done link, bundled for the scheduler.
interface div_scheduler_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic                  rsp_err;
    logic                  div_start;
    logic [WIDTH-1:0]      div_dividend;
    logic [WIDTH-1:0]      div_divisor;
    logic [WIDTH-1:0]      div_quotient;
    logic [WIDTH-1:0]      div_remainder;
    logic                  div_done;

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder, div_done,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
               div_start, div_dividend, div_divisor
    );

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder, div_done,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
               div_start, div_dividend, div_divisor
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(i_ptr) + i) % NREQ;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin front end sharing one sequential divider among NREQ requesters;
// divide-by-zero is answered locally and a watchdog bounds the wait for div_done.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic            clk,
    input logic            reset,
    div_scheduler_if.slave bus
);

    localparam int IW = clog2_min1(NREQ);
    localparam int CW = clog2_min1(TIMEOUT);

    state_e           r_state, w_next;
    logic [IW-1:0]    r_ptr, r_gnt;
    logic [WIDTH-1:0] r_dvd, r_dvs, r_q, r_r;
    logic             r_err;
    logic [CW-1:0]    r_cnt;
    logic             r_done_q;

    logic [NREQ-1:0]  w_grant, w_req_ready, w_rsp_valid;
    logic [IW-1:0]    w_idx;
    logic             w_any, w_div_start, w_done_rise, w_timeout;
    logic [WIDTH-1:0] w_sel_dvd, w_sel_dvs;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_dvd = '0;
        w_sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dvd = bus.req_dividend[i*WIDTH +: WIDTH];
                w_sel_dvs = bus.req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Only a fresh 0->1 transition counts, so a done left high by a level-style divider is ignored.
    assign w_done_rise = bus.div_done & ~r_done_q;
    assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_div_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = w_grant;
                if (w_any) w_next = (w_sel_dvs == '0) ? RESP : ISSUE;
            end
            ISSUE: begin
                w_div_start = 1'b1;
                w_next      = WAIT;
            end
            WAIT: begin
                if (w_done_rise || w_timeout) w_next = RESP;
            end
            RESP: begin
                for (int i = 0; i < NREQ; i++) w_rsp_valid[i] = (r_gnt == IW'(i));
                if (bus.rsp_ready[r_gnt]) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= bus.div_done;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_idx;
                        r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
                        r_dvd <= w_sel_dvd;
                        r_dvs <= w_sel_dvs;
                        if (w_sel_dvs == '0) begin
                            r_q   <= '1;
                            r_r   <= w_sel_dvd;
                            r_err <= 1'b1;
                        end
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    if (w_done_rise) begin
                        r_q   <= bus.div_quotient;
                        r_r   <= bus.div_remainder;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_q   <= '0;
                        r_r   <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_quotient  = r_q;
    assign bus.rsp_remainder = r_r;
    assign bus.rsp_err       = r_err;
    assign bus.div_start     = w_div_start;
    assign bus.div_dividend  = r_dvd;
    assign bus.div_divisor   = r_dvs;

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Round-robin scheduler sharing one sequential `divider` instance (start/done handshake, WIDTH-bit dividend/divisor in, quotient/remainder out) among NREQ requesters. Each requester submits an operand pair via valid/ready, the scheduler issues it to the divider, and it returns quotient/remainder/error on a per-requester response handshake. Divide-by-zero is resolved locally without occupying the divider. A timeout watchdog guarantees forward progress. Sits directly in front of the divider in the arithmetic datapath.

## Interface
- WIDTH, 4: operand/result width, matches divider WIDTH
- NREQ, 4: number of requesters, 2..8
- TIMEOUT, 64: max cycles in WAIT before an error response
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending per requester
- req_ready  out  NREQ  one-hot accept, at most one bit high
- req_dividend  in  NREQ*WIDTH  packed; requester i at [i*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  packed, same layout
- rsp_valid  out  NREQ  one-hot result valid to granted requester
- rsp_ready  in  NREQ  result accept; only granted bit is examined
- rsp_quotient  out  WIDTH  shared result bus
- rsp_remainder  out  WIDTH  shared result bus
- rsp_err  out  1  1 = divide-by-zero or timeout
- div_start  out  1  one-cycle start pulse to divider
- div_dividend, div_divisor  out  WIDTH  operands, stable from ISSUE through WAIT
- div_quotient, div_remainder  in  WIDTH  divider results
- div_done  in  1  divider completion (pulse or level)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner = first requester with req_valid at or after rr_ptr (wrapping). req_ready[winner]=1 combinationally. On that cycle's edge: latch operands, grant index g, rr_ptr <= (g+1) mod NREQ.
  - divisor != 0: go ISSUE.
  - divisor == 0: rsp_quotient = all ones, rsp_remainder = dividend, rsp_err = 1, go RESP; div_start never asserted.
- ISSUE: div_start=1 for exactly one cycle; clear timeout counter; go WAIT.
- WAIT: capture div_quotient/div_remainder on rising edge of div_done (div_done=1 and registered div_done=0), rsp_err=0, go RESP. Counter reaching TIMEOUT-1 without edge: rsp_err=1, results 0, go RESP. div_done outside WAIT is ignored.
- RESP: rsp_valid[g]=1, results held stable. rsp_ready[g]=1 -> IDLE. Other rsp_ready bits ignored.
- Requester may drop req_valid before ready without effect. Operands not sampled outside the accept cycle.

## Timing
- Reset: state IDLE, rr_ptr 0, all outputs 0 (req_ready combinational, thus 0 only when no req_valid), div_done edge register 0.
- Accept at edge k: div_start high cycle k+1, WAIT from k+2, rsp_valid the cycle after the div_done rising edge.
- Divide-by-zero: rsp_valid in cycle k+1.
- Throughput: one request in flight; one IDLE bubble after every RESP handshake; a req_valid arriving during RESP waits for IDLE.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,..,NREQ-1,0.
- Reset mid-operation: FSM aborts immediately, no response is produced, and div_start drops asynchronously. The divider shares the same reset.
- div_done already high when entering WAIT (level-style stale done) does not complete the op. Only a fresh rising edge does.

## Structure
- Package div_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default WIDTH/NREQ/TIMEOUT localparams, $clog2-based index/counter width constants.
- Sub-module rr_arbiter (NREQ): combinational round-robin winner from req mask and rr_ptr, returning one-hot grant and binary index. The pointer register stays in div_scheduler.
- The divider is instantiated outside the block. The bench wires the existing divider to the div_* ports.

## Test plan
- Single requester 0 sends 6/2, then 9/4, 15/3 -> responses q=3 r=0, q=2 r=1, q=5 r=0, err=0. Exactly one div_start per request.
- Requesters 0..3 send simultaneously 7/3, 8/8, 4/5, 0/3 -> grant order 0,1,2,3. Responses q=2 r=1, q=1 r=0, q=0 r=4, q=0 r=0, each on the correct rsp_valid bit.
- Requester 2 sends 9/0 -> rsp_valid[2] the cycle after accept, q=4'hF, r=9, err=1, div_start never high.
- Divider model holds done low -> rsp_err=1 exactly TIMEOUT cycles after WAIT entry. Next request completes normally.
- rsp_ready held low 10 cycles in RESP -> results stable, no new grant. After accept, one IDLE cycle precedes the next req_ready.
- Reset asserted during WAIT -> all outputs 0 asynchronously. After release, rr_ptr=0 and a request of 15/3 returns q=5 r=0.
